sd4_mac_ctrl: RTL
=================

Name: sd4_mac_ctrl

Overview:
- Sequencing controller for the SD4 MAC alignment/accumulate path.
- Accepts one 9-lane exponent vector per handshake and computes the signed maximum exponent.
- Issues exponents and exp_max to the alignment stage, timed to match the registered stage-1 partial products.
- Generates accumulator clear/enable strobes, counts vectors per dot product, and presents a valid/ready result handshake.

Parameters:
- NUM_PP, 9, number of partial-product lanes.
- EXP_W, 5, signed exponent width per lane.
- LEN_W, 8, width of the group-length configuration and counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort: flush pipeline, return to IDLE.
- cfg_acc_len  input  LEN_W  vectors per dot product; sampled on the first accept of a group; 0 is treated as 1.
- in_valid  input  1  exponent vector valid.
- in_ready  output  1  controller can accept.
- in_exp  input  NUM_PP*EXP_W  packed signed exponents; lane i is bits [i*EXP_W +: EXP_W].
- s2_exp  output  NUM_PP*EXP_W  registered exponents to the alignment stage.
- s2_exp_max  output  EXP_W  registered signed max of s2_exp lanes.
- s2_vld  output  1  s2_exp/s2_exp_max hold an accepted vector this cycle.
- acc_en  output  1  aligned products are valid; accumulator adds this cycle.
- acc_clr  output  1  with acc_en: first vector of the group; accumulator loads instead of adds.
- out_valid  output  1  accumulated dot product is complete.
- out_ready  input  1  downstream takes the result.
- grp_cnt  output  LEN_W  vectors accepted in the current group.
- busy  output  1  state != IDLE or any pipeline flag set.

Behaviour:
- Reset (rst=0, async) drives all outputs to 0 except in_ready, and sets state=IDLE. in_ready is combinational, so it is 1 during reset.
- Handshake:
  - Accept = in_valid && in_ready.
  - in_ready = 1 in IDLE and RUN, 0 in DRAIN and HOLD.
  - in_ready does not depend on in_valid.
- Exp_max: combinational signed compare tree over the 9 lanes of in_exp. Example: lanes {-3, 7, -16, ...} give 7; all lanes -16 give -16.
- Pipeline for a vector accepted in cycle T:
  - T+1: s2_exp = in_exp, s2_exp_max = max, s2_vld = 1. Values hold when s2_vld = 0.
  - T+2: acc_en = 1. acc_clr = 1 iff this is vector 1 of its group.
  - Total latency from accept to acc_en is 2 cycles.
  - s2_vld and acc_en are single-cycle pulses per vector.
- State machine:
  - IDLE: on accept, latch len = max(cfg_acc_len, 1), set grp_cnt = 1, tag the vector as first. Go to DRAIN if len == 1, else RUN.
  - RUN: on accept, grp_cnt++. Go to DRAIN when grp_cnt + 1 == len. Otherwise stay in RUN; gaps with in_valid = 0 are allowed.
  - DRAIN: wait for the last vector's acc_en cycle. In the following cycle, out_valid = 1 and state = HOLD.
  - HOLD: out_valid stays 1 until out_ready. On out_ready, go to IDLE next cycle with out_valid = 0 and grp_cnt = 0.
- Back-to-back: full throughput in RUN, one vector per cycle. The minimum gap between the last accept of a group and the first accept of the next is 4 cycles (T+2 acc_en, T+3 out_valid, out_ready, IDLE).
- cfg_acc_len changes mid-group are ignored until the next IDLE accept.
- grp_cnt never wraps: len ≤ 2^LEN_W − 1, so the terminal count is reached first.
- clr (synchronous, highest priority after rst):
  - Next cycle: state = IDLE, grp_cnt = 0, s2_vld = acc_en = acc_clr = out_valid = 0.
  - In-flight vectors are discarded.
  - An accept in the same cycle as clr is dropped.
- clr together with out_ready in HOLD: clr wins, with the same result (IDLE).
- Reset asserted mid-group: immediate return to the reset values, with no partial output.

Test Plan:
- Reset then idle: rst released, in_valid = 0 → in_ready = 1; s2_vld, acc_en, out_valid, busy = 0.
- Exp max: accept in_exp lanes {-16, -5, 3, 15, 0, -1, 2, 15, -8} with len = 1:
  - s2_exp_max = 15 and s2_vld = 1 at T+1.
  - acc_en = acc_clr = 1 at T+2.
  - out_valid = 1 at T+3.
- Group of 4, continuous in_valid, out_ready = 1:
  - acc_en at T+2..T+5; acc_clr only at T+2.
  - in_ready falls after the 4th accept.
  - out_valid is a single pulse at T+6; the next accept is possible at T+7.
- Backpressure: len = 2, out_ready = 0 for 5 cycles → out_valid held 5+ cycles and in_ready = 0 throughout. Raising out_ready returns to IDLE next cycle with in_ready = 1.
- cfg_acc_len = 0 and bubbles: len treated as 1. With len = 3 and in_valid gaps of 2 cycles, grp_cnt = 1, 2, 3 and exactly one acc_clr.
- Abort: len = 5, clr asserted after 3 accepts while acc_en is pending → next cycle all strobes 0, state IDLE, no out_valid. The next group's first vector gets acc_clr = 1.

Source files
------------

// File: rtl/sd4_mac_ctrl.sv
// Sequencing controller for the SD4 MAC alignment/accumulate path: signed max-exponent
// tree, two-stage strobe pipeline matched to stage-1 products, and group/result handshake.
module sd4_mac_ctrl #(
    parameter int NUM_PP = 9,
    parameter int EXP_W  = 5,
    parameter int LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [LEN_W-1:0]        cfg_acc_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_PP*EXP_W-1:0] in_exp,
    output logic [NUM_PP*EXP_W-1:0] s2_exp,
    output logic [EXP_W-1:0]        s2_exp_max,
    output logic                    s2_vld,
    output logic                    acc_en,
    output logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LEN_W-1:0]        grp_cnt,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t                    state;
    state_t                    state_nx;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          len_nx;
    logic [LEN_W-1:0]          cnt_nx;
    logic [LEN_W-1:0]          cnt_inc;
    logic [LEN_W-1:0]          len_eff;
    logic                      accept;
    logic                      first_tag;
    logic                      last_tag;
    logic                      s2_first;
    logic                      s2_last;
    logic                      acc_last;
    logic signed [EXP_W-1:0]   in_exp_max;

    // Balanced pairwise reduction: stride doubles each level, lane 0 ends with the max.
    function automatic logic signed [EXP_W-1:0] max_tree(input logic [NUM_PP*EXP_W-1:0] v);
        logic signed [EXP_W-1:0] t [NUM_PP];
        for (int i = 0; i < NUM_PP; i++) begin
            t[i] = v[i*EXP_W +: EXP_W];
        end
        for (int s = 1; s < NUM_PP; s = s * 2) begin
            for (int i = 0; i + s < NUM_PP; i = i + 2 * s) begin
                if (t[i + s] > t[i]) begin
                    t[i] = t[i + s];
                end
            end
        end
        return t[0];
    endfunction

    assign in_exp_max = max_tree(in_exp);

    assign in_ready  = (state == IDLE) || (state == RUN);
    assign accept    = in_valid && in_ready && !clr;
    assign len_eff   = (cfg_acc_len == '0) ? ONE : cfg_acc_len;
    assign cnt_inc   = grp_cnt + ONE;
    assign first_tag = (state == IDLE);

    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE) || s2_vld || acc_en;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_nx = state;
        cnt_nx   = grp_cnt;
        len_nx   = len_q;
        last_tag = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    len_nx   = len_eff;
                    cnt_nx   = ONE;
                    last_tag = (len_eff == ONE);
                    state_nx = last_tag ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_nx   = cnt_inc;
                    last_tag = (cnt_inc == len_q);
                    if (last_tag) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last vector's acc_en cycle is the one carrying acc_last.
                if (acc_last) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grp_cnt  <= '0;
            len_q    <= '0;
            s2_vld   <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            acc_en   <= 1'b0;
            acc_clr  <= 1'b0;
            acc_last <= 1'b0;
        end else begin
            state    <= state_nx;
            grp_cnt  <= cnt_nx;
            len_q    <= len_nx;
            s2_vld   <= accept;
            s2_first <= accept && first_tag;
            s2_last  <= accept && last_tag;
            acc_en   <= s2_vld && !clr;
            acc_clr  <= s2_vld && s2_first && !clr;
            acc_last <= s2_vld && s2_last && !clr;
        end
    end

    // NOTE: the exponent registers are reset as well because they are visible outputs that
    // must read 0 after reset; otherwise they only load on accept and hold in between.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_exp     <= '0;
            s2_exp_max <= '0;
        end else if (accept) begin
            s2_exp     <= in_exp;
            s2_exp_max <= in_exp_max;
        end
    end

endmodule
